decode_queue: RTL and testbench
===============================

// Module: decode_queue
// PURPOSE
//  Parametrised successor to the per-core DECODE stage: decodes an instruction word into
//  register addresses, immediate, NZP mask and control signals, then buffers the decoded
//  micro-ops in a DEPTH-entry FIFO with valid/ready on both sides. Sits between fetcher and
//  execute so fetch can run ahead. Supports flush, and stops accepting input after a RET.
// PARAMETERS
//  INSTR_WIDTH    16  instruction word width; opcode = instr[INSTR_WIDTH-1 -: 4]
//  REG_ADDR_BITS  4   register address width R; requires 4+3*R <= INSTR_WIDTH
//  IMM_BITS       8   immediate width; imm = instr[IMM_BITS-1:0]; requires IMM_BITS <= INSTR_WIDTH-4-R
//  DEPTH          4   FIFO entries; power of two, >= 2
// PORTS
//  clk                         in   1       clock, rising edge
//  reset                       in   1       synchronous, active-high
//  flush                       in   1       discard all buffered entries
//  in_valid                    in   1       instruction valid from fetcher
//  in_ready                    out  1       decoder can accept instruction
//  instruction                 in   INSTR_WIDTH  raw instruction word
//  out_valid                   out  1       head entry valid
//  out_ready                   in   1       execute consumes head entry
//  decoded_rd/rs/rt_address    out  R each  instr[W-5 -: R], next R, next R below that
//  decoded_nzp                 out  3       instr[W-5 -: 3]
//  decoded_immediate           out  IMM_BITS
//  decoded_reg_write_enable, decoded_mem_read_enable, decoded_mem_write_enable,
//  decoded_nzp_write_enable, decoded_alu_output_mux, decoded_pc_mux, decoded_ret
//                              out  1 each  control bits
//  decoded_reg_input_mux       out  2       00 ALU, 01 memory, 10 immediate
//  decoded_alu_arithmetic_mux  out  2       00 ADD, 01 SUB, 10 MUL, 11 DIV
//  decoded_illegal             out  1       unrecognised opcode (see CONFIGURATION)
//  count                       out  $clog2(DEPTH)+1  entries held
// BEHAVIOUR
//  - Opcode map: 0 NOP, 1 BRnzp(pc_mux), 2 CMP(alu_out_mux,nzp_we), 3-6 ADD/SUB/MUL/DIV
//    (reg_we, in_mux 00, arith 00..11), 7 LDR(reg_we, in_mux 01, mem_re), 8 STR(mem_we),
//    9 CONST(reg_we, in_mux 10), F RET(ret). All unlisted control bits 0. A..E: NOP.
//  - Decode is combinational on input; the full decoded record is written into the FIFO.
//  - Push = in_valid & in_ready; pop = out_valid & out_ready. Push and pop in same cycle
//    both take effect, count unchanged. Pointers wrap modulo DEPTH.
//  - Latency: instruction pushed in cycle N is visible at head with out_valid=1 in N+1 at
//    earliest (no combinational in->out path). Outputs are the head entry; all decoded_*
//    outputs are 0 when out_valid=0.
//  - in_ready = (count < DEPTH) & ~flush & (state==RUN). No push when full, even with pop.
//  - FSM: RUN -> HALT when a RET is pushed; HALT -> RUN when that RET is popped, or on
//    flush. In HALT in_ready=0. Entries ahead of the RET drain normally.
//  - flush: next cycle count=0, pointers=0, out_valid=0, state=RUN; a pop asserted in the
//    flush cycle is ignored; in_ready=0 during flush so no push.
//  - reset (priority over flush): count=0, pointers=0, state=RUN, out_valid=0,
//    in_ready=1 from first cycle after reset deasserts, all decoded_* = 0.
//  - out_valid holds and head entry stays stable while out_ready=0.
// CONFIGURATION
//  DECODE_ILLEGAL_TRAP_EN defined: opcodes A..E set decoded_illegal=1, all other control
//   bits 0, and are treated like RET for the FSM (enter HALT until popped or flushed).
//  Undefined: decoded_illegal tied 0; opcodes A..E decode as plain NOP, no HALT.
// TESTING
//  1 Reset, push 0x3123 (ADD R1,R2,R3), out_ready=1 -> next cycle out_valid=1, rd=1 rs=2
//    rt=3, reg_we=1, in_mux=00, arith=00; count returns to 0 after pop.
//  2 out_ready=0, push 5 instrs back-to-back -> 4 accepted, in_ready=0, count=4; then
//    out_ready=1 -> entries pop in order, simultaneous push/pop keeps count constant.
//  3 Push 0x9A7F (CONST R10,0x7F) then 0xF000 (RET) then 0x0000 -> CONST imm=0x7F
//    in_mux=10; in_ready=0 after RET accepted; returns 1 the cycle after RET pops.
//  4 Fill 3 entries, assert flush with out_ready=1 -> next cycle count=0, out_valid=0,
//    no entry popped, in_ready=1.
//  5 Push 0xA000: with DECODE_ILLEGAL_TRAP_EN -> decoded_illegal=1, HALT until popped;
//    without -> all controls 0, decoded_illegal=0, in_ready stays 1.
//  6 Params INSTR_WIDTH=24, REG_ADDR_BITS=5, IMM_BITS=12, DEPTH=8: push 0x7_2_B... fields
//    land at [19:15],[14:10],[9:5]; LDR sets mem_re=1, in_mux=01; 8 entries before full.

Source files
------------

// File: rtl/decode_queue.sv
// decode_queue
//   Decodes an instruction word into register addresses, immediate, NZP mask
//   and control bits, and buffers the decoded micro-ops in a DEPTH-entry FIFO
//   so that fetch can run ahead of execute. Accepts no further input once a
//   RET has been taken until that RET is consumed (or the queue is flushed).
//
//   Optional feature macro: DECODE_ILLEGAL_TRAP_EN
//     defined   : opcodes A..E raise decoded_illegal and halt input like RET
//     undefined : decoded_illegal tied 0, opcodes A..E decode as NOP
//
// Ports
//   clk, reset                 clock (rising edge), synchronous active-high reset
//   flush                      drop all buffered entries
//   in_valid / in_ready        instruction handshake from the fetcher
//   instruction                raw instruction word (INSTR_WIDTH)
//   out_valid / out_ready      head-entry handshake towards execute
//   decoded_*                  fields of the head entry, all 0 when out_valid=0
//   count                      number of entries held
module decode_queue #(
  parameter int INSTR_WIDTH   = 16,
  parameter int REG_ADDR_BITS = 4,
  parameter int IMM_BITS      = 8,
  parameter int DEPTH         = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INSTR_WIDTH-1:0]     instruction,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [REG_ADDR_BITS-1:0]   decoded_rd_address,
  output logic [REG_ADDR_BITS-1:0]   decoded_rs_address,
  output logic [REG_ADDR_BITS-1:0]   decoded_rt_address,
  output logic [2:0]                 decoded_nzp,
  output logic [IMM_BITS-1:0]        decoded_immediate,
  output logic                       decoded_reg_write_enable,
  output logic                       decoded_mem_read_enable,
  output logic                       decoded_mem_write_enable,
  output logic                       decoded_nzp_write_enable,
  output logic                       decoded_alu_output_mux,
  output logic                       decoded_pc_mux,
  output logic                       decoded_ret,
  output logic [1:0]                 decoded_reg_input_mux,
  output logic [1:0]                 decoded_alu_arithmetic_mux,
  output logic                       decoded_illegal,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int R     = REG_ADDR_BITS;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [R-1:0]        rd;
    logic [R-1:0]        rs;
    logic [R-1:0]        rt;
    logic [2:0]          nzp;
    logic [IMM_BITS-1:0] imm;
    logic                reg_we;
    logic                mem_re;
    logic                mem_we;
    logic                nzp_we;
    logic                alu_out_mux;
    logic                pc_mux;
    logic                ret;
    logic [1:0]          reg_in_mux;
    logic [1:0]          alu_arith_mux;
    logic                illegal;
  } uop_t;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  function automatic uop_t decode(input logic [INSTR_WIDTH-1:0] instr);
    uop_t       u;
    logic [3:0] op;
    u      = '0;
    op     = instr[INSTR_WIDTH-1 -: 4];
    u.rd   = instr[INSTR_WIDTH-5 -: R];
    u.rs   = instr[INSTR_WIDTH-5-R -: R];
    u.rt   = instr[INSTR_WIDTH-5-2*R -: R];
    u.nzp  = instr[INSTR_WIDTH-5 -: 3];
    u.imm  = instr[IMM_BITS-1:0];
    case (op)
      4'h1: u.pc_mux = 1'b1;
      4'h2: begin
        u.alu_out_mux = 1'b1;
        u.nzp_we      = 1'b1;
      end
      4'h3, 4'h4, 4'h5, 4'h6: begin
        u.reg_we        = 1'b1;
        u.reg_in_mux    = 2'b00;
        u.alu_arith_mux = 2'(op - 4'h3);
      end
      4'h7: begin
        u.reg_we     = 1'b1;
        u.reg_in_mux = 2'b01;
        u.mem_re     = 1'b1;
      end
      4'h8: u.mem_we = 1'b1;
      4'h9: begin
        u.reg_we     = 1'b1;
        u.reg_in_mux = 2'b10;
      end
      4'hF: u.ret = 1'b1;
`ifdef DECODE_ILLEGAL_TRAP_EN
      4'hA, 4'hB, 4'hC, 4'hD, 4'hE: u.illegal = 1'b1;
`endif
      default: ;
    endcase
    return u;
  endfunction

  // An entry that stops the input side until it leaves the queue.
  function automatic logic halts(input uop_t u);
    return u.ret | u.illegal;
  endfunction

  state_t             state, state_nxt;
  uop_t               uop_p0;
  uop_t               fifo_p1 [DEPTH];
  uop_t               head_p1;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   cnt;
  logic               vld_p1;
  logic               push, pop;

  // ---- stage p0: combinational decode of the incoming word ----
  assign uop_p0 = decode(instruction);
  assign push   = in_valid & in_ready;
  // A pop requested during flush is discarded together with the entry.
  assign pop    = vld_p1 & out_ready & ~flush;

  // ---- stage p1: FIFO storage, head presented to execute ----
  always_ff @(posedge clk) begin
    if (push) fifo_p1[wr_ptr] <= uop_p0;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign vld_p1  = (cnt != '0);
  assign head_p1 = vld_p1 ? fifo_p1[rd_ptr] : '0;

  // Input-side FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Input-side FSM: next state
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN:     if (push && halts(uop_p0)) state_nxt = HALT;
        HALT:    if (pop && halts(head_p1)) state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  // Input-side FSM: outputs (no push when full, even if the head pops)
  always_comb begin
    in_ready = 1'b0;
    if ((cnt != FULL) && !flush && (state == RUN)) in_ready = 1'b1;
  end

  assign out_valid                  = vld_p1;
  assign count                      = cnt;
  assign decoded_rd_address         = head_p1.rd;
  assign decoded_rs_address         = head_p1.rs;
  assign decoded_rt_address         = head_p1.rt;
  assign decoded_nzp                = head_p1.nzp;
  assign decoded_immediate          = head_p1.imm;
  assign decoded_reg_write_enable   = head_p1.reg_we;
  assign decoded_mem_read_enable    = head_p1.mem_re;
  assign decoded_mem_write_enable   = head_p1.mem_we;
  assign decoded_nzp_write_enable   = head_p1.nzp_we;
  assign decoded_alu_output_mux     = head_p1.alu_out_mux;
  assign decoded_pc_mux             = head_p1.pc_mux;
  assign decoded_ret                = head_p1.ret;
  assign decoded_reg_input_mux      = head_p1.reg_in_mux;
  assign decoded_alu_arithmetic_mux = head_p1.alu_arith_mux;
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign decoded_illegal            = head_p1.illegal;
`else
  assign decoded_illegal            = 1'b0;
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Testbench for decode_queue (default parameters). Directed scenarios followed
// by randomized traffic; a queue-based reference model predicts the head entry,
// occupancy and in_ready every cycle.
module tb_decode_queue;

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] instruction;
  logic [3:0]  rd, rs, rt;
  logic [2:0]  nzp;
  logic [7:0]  imm;
  logic        reg_we, mem_re, mem_we, nzp_we, alu_out_mux, pc_mux, ret, illegal;
  logic [1:0]  in_mux, arith;
  logic [2:0]  count;

  decode_queue dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
    .out_valid(out_valid), .out_ready(out_ready),
    .decoded_rd_address(rd), .decoded_rs_address(rs), .decoded_rt_address(rt),
    .decoded_nzp(nzp), .decoded_immediate(imm),
    .decoded_reg_write_enable(reg_we), .decoded_mem_read_enable(mem_re),
    .decoded_mem_write_enable(mem_we), .decoded_nzp_write_enable(nzp_we),
    .decoded_alu_output_mux(alu_out_mux), .decoded_pc_mux(pc_mux),
    .decoded_ret(ret), .decoded_reg_input_mux(in_mux),
    .decoded_alu_arithmetic_mux(arith), .decoded_illegal(illegal),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] rd, rs, rt;
    logic [2:0] nzp;
    logic [7:0] imm;
    logic       reg_we, mem_re, mem_we, nzp_we, alu_out_mux, pc_mux, ret;
    logic [1:0] in_mux, arith;
    logic       illegal;
  } rec_t;

  rec_t act;
  assign act = {rd, rs, rt, nzp, imm, reg_we, mem_re, mem_we, nzp_we,
                alu_out_mux, pc_mux, ret, in_mux, arith, illegal};

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference decode straight from the opcode table.
  function automatic rec_t ref_decode(input logic [15:0] w);
    rec_t r;
    int   op;
    r     = '0;
    op    = int'(w >> 12);
    r.rd  = 4'((w >> 8) & 16'hF);
    r.rs  = 4'((w >> 4) & 16'hF);
    r.rt  = 4'(w & 16'hF);
    r.nzp = 3'((w >> 9) & 16'h7);
    r.imm = 8'(w & 16'hFF);
    if (op >= 3 && op <= 6) begin
      r.reg_we = 1'b1;
      r.arith  = 2'(op - 3);
    end else if (op == 1) r.pc_mux = 1'b1;
    else if (op == 2) begin r.alu_out_mux = 1'b1; r.nzp_we = 1'b1; end
    else if (op == 7) begin r.reg_we = 1'b1; r.in_mux = 2'b01; r.mem_re = 1'b1; end
    else if (op == 8) r.mem_we = 1'b1;
    else if (op == 9) begin r.reg_we = 1'b1; r.in_mux = 2'b10; end
    else if (op == 15) r.ret = 1'b1;
    else if (op >= 10 && op <= 14) r.illegal = TRAP;
    return r;
  endfunction

  // Reference model: expected contents of the queue and halt status.
  rec_t q[$];
  bit   halted   = 1'b0;
  bit   model_ok = 1'b0;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      q.delete();
      halted   = 1'b0;
      model_ok = 1'b1;
    end else if (flush) begin
      q.delete();
      halted = 1'b0;
    end else begin
      bit   do_push, do_pop;
      rec_t nr;
      do_push = in_valid && (q.size() < 4) && !halted;
      do_pop  = (q.size() > 0) && out_ready;
      nr      = ref_decode(instruction);
      if (do_pop) begin
        if (q[0].ret || q[0].illegal) halted = 1'b0;
        void'(q.pop_front());
      end
      if (do_push) begin
        q.push_back(nr);
        if (nr.ret || nr.illegal) halted = 1'b1;
      end
    end
  end

  // Monitor: compare DUT against the model on every falling edge.
  initial forever begin
    @(negedge clk);
    if (model_ok && !reset) begin
      rec_t exp;
      exp = (q.size() > 0) ? q[0] : '0;
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("count", 64'(count), 64'(q.size()));
      chk("in_ready", 64'(in_ready), 64'((q.size() < 4) && !flush && !halted));
      chk("head", 64'(act), 64'(exp));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instruction = 16'h0000;
    step(); step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_fields", 64'(act), 64'd0);
    step();

    // ADD R1,R2,R3 through an empty queue
    in_valid = 1'b1; instruction = 16'h3123; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_rd", 64'(rd), 64'd1);
    chk("add_rs", 64'(rs), 64'd2);
    chk("add_rt", 64'(rt), 64'd3);
    chk("add_reg_we", 64'(reg_we), 64'd1);
    chk("add_arith", 64'(arith), 64'd0);
    chk("add_in_mux", 64'(in_mux), 64'd0);
    step();
    @(negedge clk);
    chk("add_drained", 64'(count), 64'd0);
    step();

    // Fill to capacity with the consumer stalled
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      instruction = 16'h4000 + 16'(i * 16'h0111);
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    step();
    out_ready = 1'b1; in_valid = 1'b1; instruction = 16'h6321;
    step();
    @(negedge clk);
    chk("full_pop_nopush", 64'(count), 64'd3);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("pushpop_count", 64'(count), 64'd3);
    repeat (4) step();
    @(negedge clk);
    chk("drain_count", 64'(count), 64'd0);
    step();

    // CONST, RET, then a word that must be refused
    out_ready = 1'b0; in_valid = 1'b1; instruction = 16'h9A7F;
    step();
    instruction = 16'hF000;
    step();
    instruction = 16'h0000;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("ret_in_ready", 64'(in_ready), 64'd0);
    chk("ret_count", 64'(count), 64'd2);
    chk("const_imm", 64'(imm), 64'h7F);
    chk("const_in_mux", 64'(in_mux), 64'd2);
    step();
    out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("ret_head", 64'(ret), 64'd1);
    chk("ret_still_halt", 64'(in_ready), 64'd0);
    step();
    @(negedge clk);
    chk("ret_resume", 64'(in_ready), 64'd1);
    step();

    // Flush with three entries and a pending pop
    out_ready = 1'b0; in_valid = 1'b1;
    instruction = 16'h3111; step();
    instruction = 16'h4222; step();
    instruction = 16'h5333; step();
    in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    chk("flush_pre_count", 64'(count), 64'd3);
    step();
    flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready1", 64'(in_ready), 64'd1);
    step();

    // Opcode A
    in_valid = 1'b1; instruction = 16'hA000;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("opA_illegal", 64'(illegal), 64'(TRAP));
    chk("opA_in_ready", 64'(in_ready), 64'(!TRAP));
    chk("opA_reg_we", 64'(reg_we), 64'd0);
    step();
    out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("opA_popped", 64'(in_ready), 64'd1);
    step();

    // Randomized traffic
    repeat (3000) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      instruction = 16'($urandom);
      out_ready   = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 39) == 0);
      reset       = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
